// File: rtl/fir_pkg.sv
// Shared constants for the FIR output stream path.
package fir_pkg;

    localparam int FIR_DATA_WIDTH = 32;
    localparam int FIR_DEPTH      = 16;
    localparam int DEPTH_W        = $clog2(FIR_DEPTH);

    // Pointer width for a FIFO of the given power-of-two depth.
    function automatic int clog2_depth(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fir_frame_chk.sv
// Frame-length checker: counts accepted samples per frame, counts frames and
// flags a sticky length error when tlast disagrees with data_length.
module fir_frame_chk (
    input  logic        axis_clk,
    input  logic        axis_rst,
    input  logic        acc,
    input  logic        acc_last,
    input  logic [31:0] data_length,
    input  logic        clr_err,
    output logic [15:0] frame_cnt,
    output logic        len_err
);

    logic [31:0] in_cnt;
    logic [31:0] cnt_inc;
    logic        set_err;

    assign cnt_inc = in_cnt + 32'd1;

    // Early tlast, late tlast and a frame that runs past its length all flag.
    assign set_err = acc && (acc_last ? (cnt_inc != data_length)
                                      : (cnt_inc >= data_length));

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            in_cnt    <= '0;
            frame_cnt <= '0;
            len_err   <= 1'b0;
        end else begin
            if (acc) begin
                if (acc_last) begin
                    in_cnt    <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    in_cnt <= cnt_inc;
                end
            end
            // A new error wins over a same-cycle clear.
            if (set_err)
                len_err <= 1'b1;
            else if (clr_err)
                len_err <= 1'b0;
        end
    end

endmodule

// File: rtl/fir_out_fifo.sv
// First-word-fall-through output FIFO behind the FIR engine, with per-frame
// length checking and a frame_done pulse when a frame's last word leaves.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH = FIR_DATA_WIDTH,
    parameter int pDEPTH      = FIR_DEPTH
) (
    input  logic                          axis_clk,
    input  logic                          axis_rst,
    input  logic                          ss_tvalid,
    input  logic [pDATA_WIDTH-1:0]        ss_tdata,
    input  logic                          ss_tlast,
    output logic                          ss_tready,
    output logic                          sm_tvalid,
    output logic [pDATA_WIDTH-1:0]        sm_tdata,
    output logic                          sm_tlast,
    input  logic                          sm_tready,
    input  logic [31:0]                   data_length,
    input  logic                          clr_err,
    output logic [clog2_depth(pDEPTH):0]  fifo_count,
    output logic [15:0]                   frame_cnt,
    output logic                          len_err,
    output logic                          frame_done
);

    localparam int AW = clog2_depth(pDEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(pDEPTH);

    logic [pDATA_WIDTH:0] mem [pDEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [pDATA_WIDTH:0] head;
    logic                 push;
    logic                 pop;

    // Handshake: a word moves only in a cycle where valid and ready are both
    // high; valid never waits on ready, and a held word stays stable until taken.
    assign ss_tready  = !axis_rst && (count < FULL_CNT);
    assign sm_tvalid  = !axis_rst && (count != '0);
    assign push       = ss_tvalid && ss_tready;
    assign pop        = sm_tvalid && sm_tready;

    assign head       = mem[rd_ptr];
    assign sm_tdata   = sm_tvalid ? head[pDATA_WIDTH-1:0] : '0;
    assign sm_tlast   = sm_tvalid ? head[pDATA_WIDTH] : 1'b0;
    assign fifo_count = count;

    always_ff @(posedge axis_clk) begin
        if (push)
            mem[wr_ptr] <= {ss_tlast, ss_tdata};
    end

    // Pointers are exactly AW bits wide, so they wrap modulo pDEPTH for free.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frame_done <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            frame_done <= pop && head[pDATA_WIDTH];
        end
    end

    fir_frame_chk u_frame_chk (
        .axis_clk    (axis_clk),
        .axis_rst    (axis_rst),
        .acc         (push),
        .acc_last    (ss_tlast),
        .data_length (data_length),
        .clr_err     (clr_err),
        .frame_cnt   (frame_cnt),
        .len_err     (len_err)
    );

endmodule

// File: tb/tb_fir_out_fifo.sv
// Bench for fir_out_fifo: random data against a queue-based reference model,
// checked every cycle, plus directed scenario checks.
module tb_fir_out_fifo;

    localparam int W = 32;
    localparam int D = 16;

    logic          axis_clk = 1'b0;
    logic          axis_rst;
    logic          ss_tvalid;
    logic [W-1:0]  ss_tdata;
    logic          ss_tlast;
    logic          ss_tready;
    logic          sm_tvalid;
    logic [W-1:0]  sm_tdata;
    logic          sm_tlast;
    logic          sm_tready;
    logic [31:0]   data_length;
    logic          clr_err;
    logic [4:0]    fifo_count;
    logic [15:0]   frame_cnt;
    logic          len_err;
    logic          frame_done;

    always #5 axis_clk = ~axis_clk;

    fir_out_fifo #(.pDATA_WIDTH(W), .pDEPTH(D)) dut (
        .axis_clk    (axis_clk),
        .axis_rst    (axis_rst),
        .ss_tvalid   (ss_tvalid),
        .ss_tdata    (ss_tdata),
        .ss_tlast    (ss_tlast),
        .ss_tready   (ss_tready),
        .sm_tvalid   (sm_tvalid),
        .sm_tdata    (sm_tdata),
        .sm_tlast    (sm_tlast),
        .sm_tready   (sm_tready),
        .data_length (data_length),
        .clr_err     (clr_err),
        .fifo_count  (fifo_count),
        .frame_cnt   (frame_cnt),
        .len_err     (len_err),
        .frame_done  (frame_done)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: expected FIFO contents {tlast, data} and frame state.
    logic [W:0]  exp_q[$];
    logic [31:0] m_in_cnt;
    logic [15:0] m_frame_cnt;
    logic        m_len_err;
    logic        m_done;
    int          done_pulses;
    int          pops;
    bit          last_push;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic       push;
        logic       pop;
        logic       err;
        logic [31:0] n;
        logic [W:0] head;
        #1;
        head = (!axis_rst && exp_q.size() > 0) ? exp_q[0] : '0;
        check("ss_tready", ss_tready, !axis_rst && (exp_q.size() < D));
        check("sm_tvalid", sm_tvalid, !axis_rst && (exp_q.size() > 0));
        check("sm_tdata", sm_tdata, head[W-1:0]);
        check("sm_tlast", sm_tlast, head[W]);
        check("fifo_count", fifo_count, exp_q.size());
        check("len_err", len_err, m_len_err);
        check("frame_cnt", frame_cnt, m_frame_cnt);
        check("frame_done", frame_done, m_done);
        if (frame_done) done_pulses++;
        push = !axis_rst && ss_tvalid && (exp_q.size() < D);
        pop  = !axis_rst && sm_tready && (exp_q.size() > 0);
        last_push = push;
        if (axis_rst) begin
            exp_q.delete();
            m_in_cnt    = '0;
            m_frame_cnt = '0;
            m_len_err   = 1'b0;
            m_done      = 1'b0;
        end else begin
            m_done = 1'b0;
            if (pop) begin
                m_done = exp_q[0][W];
                void'(exp_q.pop_front());
                pops++;
            end
            err = 1'b0;
            if (push) begin
                exp_q.push_back({ss_tlast, ss_tdata});
                n = m_in_cnt + 1;
                err = ss_tlast ? (n != data_length) : (n >= data_length);
                if (ss_tlast) begin
                    m_in_cnt = '0;
                    m_frame_cnt = m_frame_cnt + 16'd1;
                end else begin
                    m_in_cnt = n;
                end
            end
            if (err) m_len_err = 1'b1;
            else if (clr_err) m_len_err = 1'b0;
        end
        @(posedge axis_clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic l);
        int guard;
        ss_tvalid = 1'b1;
        ss_tdata  = d;
        ss_tlast  = l;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!last_push && guard < 300);
        if (!last_push) begin
            n_cmp++;
            n_mis++;
            $error("FAIL send_timeout: observed not-accepted expected accepted");
        end
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        sm_tready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        tick();
    endtask

    task automatic do_reset();
        axis_rst = 1'b1;
        tick();
        axis_rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] d0;
        int           p0;
        axis_rst    = 1'b1;
        ss_tvalid   = 1'b0;
        ss_tdata    = '0;
        ss_tlast    = 1'b0;
        sm_tready   = 1'b0;
        data_length = 32'd600;
        clr_err     = 1'b0;
        m_in_cnt    = '0;
        m_frame_cnt = '0;
        m_len_err   = 1'b0;
        m_done      = 1'b0;
        done_pulses = 0;
        pops        = 0;
        @(posedge axis_clk);
        #1;
        repeat (3) tick();
        axis_rst = 1'b0;
        #1;
        check("rst_release_ready", ss_tready, 1'b1);

        // Flow-through: one 600-sample frame with the sink always ready.
        sm_tready = 1'b1;
        done_pulses = 0;
        d0 = $urandom;
        send(d0, 1'b0);
        check("lat1_valid", sm_tvalid, 1'b1);
        check("lat1_data", sm_tdata, d0);
        for (int i = 1; i < 600; i++) send($urandom, i == 599);
        drain();
        check("flow_len_err", len_err, 1'b0);
        check("flow_frame_cnt", frame_cnt, 16'd1);
        check("flow_done_pulses", done_pulses, 1);

        // Fill and backpressure: 20 words offered to a stalled sink.
        data_length = 32'd1000;
        sm_tready = 1'b0;
        p0 = pops;
        for (int i = 0; i < 16; i++) send($urandom, 1'b0);
        check("bp_count", fifo_count, 5'd16);
        check("bp_ready", ss_tready, 1'b0);
        ss_tvalid = 1'b1;
        ss_tdata  = $urandom;
        repeat (3) tick();
        check("bp_still_full", fifo_count, 5'd16);
        sm_tready = 1'b1;
        send(ss_tdata, 1'b0);
        for (int i = 0; i < 3; i++) send($urandom, 1'b0);
        drain();
        check("bp_popped", pops - p0, 20);

        // Simultaneous push and pop at a steady depth of 8.
        sm_tready = 1'b0;
        for (int i = 0; i < 8; i++) send($urandom, 1'b0);
        check("sim_fill", fifo_count, 5'd8);
        sm_tready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            send($urandom, 1'b0);
            check("sim_count", fifo_count, 5'd8);
        end
        drain();

        // Length error: early tlast, sticky, clear, and set-beats-clear.
        do_reset();
        data_length = 32'd10;
        sm_tready = 1'b1;
        for (int i = 0; i < 7; i++) send($urandom, i == 6);
        check("early_tlast_err", len_err, 1'b1);
        repeat (3) tick();
        check("err_sticky", len_err, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("err_cleared", len_err, 1'b0);
        clr_err = 1'b1;
        send($urandom, 1'b1);
        clr_err = 1'b0;
        check("set_over_clr", len_err, 1'b1);
        drain();

        // Missing tlast: error must appear exactly on the 4th word.
        do_reset();
        data_length = 32'd4;
        for (int i = 0; i < 3; i++) send($urandom, 1'b0);
        check("no_tlast_3", len_err, 1'b0);
        send($urandom, 1'b0);
        check("no_tlast_4", len_err, 1'b1);
        send($urandom, 1'b0);
        check("no_tlast_5", len_err, 1'b1);
        drain();

        // Reset mid-operation with 5 words buffered and a frame already counted.
        do_reset();
        data_length = 32'd1000;
        sm_tready = 1'b0;
        for (int i = 0; i < 5; i++) send($urandom, i == 1);
        check("mid_count", fifo_count, 5'd5);
        check("mid_frames", frame_cnt, 16'd1);
        axis_rst = 1'b1;
        tick();
        axis_rst = 1'b0;
        #1;
        check("mid_rst_count", fifo_count, 5'd0);
        check("mid_rst_valid", sm_tvalid, 1'b0);
        check("mid_rst_frames", frame_cnt, 16'd0);
        check("mid_rst_ready", ss_tready, 1'b1);
        data_length = 32'd10;
        sm_tready = 1'b1;
        for (int i = 0; i < 10; i++) send($urandom, i == 9);
        drain();
        check("resume_frames", frame_cnt, 16'd1);
        check("resume_len_err", len_err, 1'b0);

        // Random traffic on both sides, checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            ss_tvalid   = 1'($urandom_range(0, 1));
            ss_tdata    = $urandom;
            ss_tlast    = ($urandom_range(0, 7) == 0);
            sm_tready   = 1'($urandom_range(0, 1));
            clr_err     = ($urandom_range(0, 9) == 0);
            data_length = $urandom_range(1, 8);
            tick();
        end
        ss_tvalid = 1'b0;
        clr_err   = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
